// File: rtl/multiplier_scheduler_pkg.sv
// mult_sched_pkg: shared types and constants for the multiplier scheduler.
package mult_sched_pkg;
    localparam int DEF_WIDTH = 4;
    localparam int COUNT_WIDTH = 8;
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        RESPOND = 2'd2
    } state_e;
endpackage

// File: rtl/multiplier_scheduler_if.sv
// multiplier_scheduler_if: request/response handshake bundle for two requesters.
interface multiplier_scheduler_if #(parameter int WIDTH = mult_sched_pkg::DEF_WIDTH);
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [2*WIDTH-1:0] req_alpha;
    logic [2*WIDTH-1:0] req_beta;
    logic [1:0]         rsp_valid;
    logic [1:0]         rsp_ready;
    logic [2*WIDTH-1:0] rsp_product;
    modport master (output req_valid, req_alpha, req_beta, rsp_ready,
                    input  req_ready, rsp_valid, rsp_product);
    modport slave  (input  req_valid, req_alpha, req_beta, rsp_ready,
                    output req_ready, rsp_valid, rsp_product);
endinterface

// File: rtl/multiplier_combinational.sv
// multiplier_combinational: unsigned WIDTH x WIDTH multiplier with full-width product.
module multiplier_combinational #(parameter int WIDTH = 4) (
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [2*WIDTH-1:0] p_o
);
    assign p_o = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};
endmodule

// File: rtl/multiplier_scheduler.sv
// multiplier_scheduler: round-robin sharing of one multiplier between two requesters.
// Optional per-requester completion counters with MULT_SCHED_STATS_EN.
module multiplier_scheduler
    import mult_sched_pkg::*;
#(parameter int WIDTH = DEF_WIDTH) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    multiplier_scheduler_if.slave  bus,
    output logic                   busy_o
`ifdef MULT_SCHED_STATS_EN
    ,
    output logic [COUNT_WIDTH-1:0] count_0_o,
    output logic [COUNT_WIDTH-1:0] count_1_o
`endif
);
    state_e             state_q, state_d;
    logic               last_q, grant_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [2*WIDTH-1:0] prod_q, prod_w;
    logic               win, hs, done;

    // On a tie the requester that was not served last wins
    assign win  = (bus.req_valid == 2'b11) ? ~last_q : bus.req_valid[1];
    assign bus.req_ready = (rst_ni && state_q == IDLE && |bus.req_valid) ? {win, ~win} : 2'b00;
    assign hs   = |bus.req_ready;
    assign done = (state_q == RESPOND) && bus.rsp_ready[grant_q];
    assign bus.rsp_valid   = (state_q == RESPOND) ? {grant_q, ~grant_q} : 2'b00;
    assign bus.rsp_product = prod_q;
    assign busy_o = (state_q != IDLE);

    always_comb begin
        state_d = (state_q == IDLE)    ? (hs ? COMPUTE : IDLE) :
                  (state_q == COMPUTE) ? RESPOND :
                  (done ? IDLE : RESPOND);
    end

    multiplier_combinational #(.WIDTH(WIDTH)) u_mul (
        .a_i (a_q),
        .b_i (b_q),
        .p_o (prod_w)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            grant_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            if (hs) begin
                grant_q <= win;
                a_q     <= win ? bus.req_alpha[2*WIDTH-1:WIDTH] : bus.req_alpha[WIDTH-1:0];
                b_q     <= win ? bus.req_beta[2*WIDTH-1:WIDTH] : bus.req_beta[WIDTH-1:0];
            end
            if (state_q == COMPUTE) prod_q <= prod_w;
            if (done) last_q <= grant_q;
        end
    end

`ifdef MULT_SCHED_STATS_EN
    logic [COUNT_WIDTH-1:0] cnt0_q, cnt1_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (done && !grant_q && cnt0_q != COUNT_MAX) cnt0_q <= cnt0_q + 1'b1;
            if (done && grant_q && cnt1_q != COUNT_MAX) cnt1_q <= cnt1_q + 1'b1;
        end
    end

    assign count_0_o = cnt0_q;
    assign count_1_o = cnt1_q;
`endif
endmodule

// File: tb/tb_multiplier_scheduler.sv
// tb_multiplier_scheduler: directed self-checking bench for multiplier_scheduler.
module tb_multiplier_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    multiplier_scheduler_if mif();

`ifdef MULT_SCHED_STATS_EN
    logic [7:0] c0, c1;
    multiplier_scheduler dut (.clk_i(clk), .rst_ni(rst_n), .bus(mif), .busy_o(busy),
                              .count_0_o(c0), .count_1_o(c1));
`else
    multiplier_scheduler dut (.clk_i(clk), .rst_ni(rst_n), .bus(mif), .busy_o(busy));
`endif

    task automatic do_reset();
        mif.req_valid = 2'b00;
        mif.rsp_ready = 2'b00;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drives one transaction from a negedge and returns the granted index and product
    task automatic run_txn(input logic [1:0] v, input bit hold,
                           output int g, output logic [7:0] p, output bit to);
        int n;
        to = 1'b0; g = -1; p = 8'h00;
        mif.req_valid = v;
        #1;
        n = 0;
        while (mif.req_ready == 2'b00 && n < 20) begin @(negedge clk); n++; end
        if (mif.req_ready == 2'b00) begin to = 1'b1; return; end
        g = mif.req_ready[1] ? 1 : 0;
        @(negedge clk);
        if (!hold) mif.req_valid[g] = 1'b0;
        n = 0;
        while (mif.rsp_valid == 2'b00 && n < 20) begin @(negedge clk); n++; end
        if (mif.rsp_valid == 2'b00) begin to = 1'b1; return; end
        p = mif.rsp_product;
        mif.rsp_ready = mif.rsp_valid;
        @(negedge clk);
        mif.rsp_ready = 2'b00;
    endtask

    task automatic test_reset();
        mif.req_alpha = 8'h00; mif.req_beta = 8'h00;
        mif.rsp_ready = 2'b00; mif.req_valid = 2'b11;
        rst_n = 1'b0;
        @(negedge clk);
        total++; if (mif.req_ready !== 2'b00) begin bad++; $display("FAIL reset_req_ready got=%b exp=00", mif.req_ready); end
        total++; if (mif.rsp_valid !== 2'b00) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=00", mif.rsp_valid); end
        total++; if (mif.rsp_product !== 8'h00) begin bad++; $display("FAIL reset_product got=%h exp=00", mif.rsp_product); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        mif.req_valid = 2'b00;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        @(negedge clk);
        mif.req_alpha = 8'h03; mif.req_beta = 8'h05; mif.req_valid = 2'b01;
        #1;
        total++; if (mif.req_ready !== 2'b01) begin bad++; $display("FAIL single_req_ready got=%b exp=01", mif.req_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle_busy got=%b exp=0", busy); end
        @(negedge clk);
        mif.req_valid = 2'b00;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_compute_busy got=%b exp=1", busy); end
        total++; if (mif.rsp_valid !== 2'b00) begin bad++; $display("FAIL single_early_valid got=%b exp=00", mif.rsp_valid); end
        @(negedge clk);
        total++; if (mif.rsp_valid !== 2'b01) begin bad++; $display("FAIL single_rsp_valid got=%b exp=01", mif.rsp_valid); end
        total++; if (mif.rsp_product !== 8'h0F) begin bad++; $display("FAIL single_product got=%h exp=0f", mif.rsp_product); end
        mif.rsp_ready = 2'b01;
        @(negedge clk);
        mif.rsp_ready = 2'b00;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_done_busy got=%b exp=0", busy); end
        total++; if (mif.rsp_valid !== 2'b00) begin bad++; $display("FAIL single_done_valid got=%b exp=00", mif.rsp_valid); end
    endtask

    task automatic test_tie();
        int g; logic [7:0] p; bit to;
        do_reset();
        mif.req_alpha = 8'hF7; mif.req_beta = 8'hF9;
        run_txn(2'b11, 1'b0, g, p, to);
        total++; if (to || g !== 0 || p !== 8'h3F) begin bad++; $display("FAIL tie_first got g=%0d p=%h to=%0d exp g=0 p=3f", g, p, to); end
        run_txn(2'b10, 1'b0, g, p, to);
        total++; if (to || g !== 1 || p !== 8'hE1) begin bad++; $display("FAIL tie_second got g=%0d p=%h to=%0d exp g=1 p=e1", g, p, to); end
    endtask

    task automatic test_fairness();
        int g; logic [7:0] p; bit to;
        mif.req_alpha = 8'h23; mif.req_beta = 8'h45;
        for (int i = 0; i < 8; i++) begin
            run_txn(2'b11, 1'b1, g, p, to);
            total++;
            if (to || g !== (i % 2) || p !== ((i % 2) ? 8'h08 : 8'h0F)) begin
                bad++; $display("FAIL fair_%0d got g=%0d p=%h to=%0d exp g=%0d", i, g, p, to, i % 2);
            end
        end
        mif.req_valid = 2'b00;
    endtask

    task automatic test_backpressure();
        mif.req_alpha = 8'h60; mif.req_beta = 8'h70; mif.req_valid = 2'b10;
        #1;
        total++; if (mif.req_ready !== 2'b10) begin bad++; $display("FAIL bp_req_ready got=%b exp=10", mif.req_ready); end
        @(negedge clk);
        mif.req_valid = 2'b00;
        @(negedge clk);
        total++; if (mif.rsp_valid !== 2'b10 || mif.rsp_product !== 8'h2A) begin bad++; $display("FAIL bp_first got v=%b p=%h exp v=10 p=2a", mif.rsp_valid, mif.rsp_product); end
        mif.rsp_ready = 2'b01;
        mif.req_valid = 2'b01;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (mif.rsp_valid !== 2'b10 || mif.rsp_product !== 8'h2A || mif.req_ready !== 2'b00 || busy !== 1'b1) begin
                bad++; $display("FAIL bp_hold_%0d got v=%b p=%h rdy=%b busy=%b exp v=10 p=2a rdy=00 busy=1", i, mif.rsp_valid, mif.rsp_product, mif.req_ready, busy);
            end
        end
        mif.req_valid = 2'b00;
        mif.rsp_ready = 2'b10;
        @(negedge clk);
        mif.rsp_ready = 2'b00;
        total++; if (busy !== 1'b0 || mif.rsp_valid !== 2'b00) begin bad++; $display("FAIL bp_release got busy=%b v=%b exp busy=0 v=00", busy, mif.rsp_valid); end
    endtask

    task automatic test_reset_mid();
        int g; logic [7:0] p; bit to;
        mif.req_alpha = 8'h02; mif.req_beta = 8'h02;
        run_txn(2'b01, 1'b0, g, p, to);
        total++; if (to || g !== 0 || p !== 8'h04) begin bad++; $display("FAIL rm_pre got g=%0d p=%h to=%0d exp g=0 p=04", g, p, to); end
        mif.req_alpha = 8'h30; mif.req_beta = 8'h30; mif.req_valid = 2'b10;
        @(negedge clk);
        mif.req_valid = 2'b00;
        @(negedge clk);
        total++; if (mif.rsp_valid !== 2'b10) begin bad++; $display("FAIL rm_in_respond got=%b exp=10", mif.rsp_valid); end
        rst_n = 1'b0;
        #1;
        total++; if (mif.rsp_valid !== 2'b00 || mif.rsp_product !== 8'h00 || busy !== 1'b0) begin bad++; $display("FAIL rm_async got v=%b p=%h busy=%b exp v=00 p=00 busy=0", mif.rsp_valid, mif.rsp_product, busy); end
        @(negedge clk);
        rst_n = 1'b1;
        mif.req_alpha = 8'h50; mif.req_beta = 8'h5F;
        run_txn(2'b11, 1'b0, g, p, to);
        total++; if (to || g !== 0 || p !== 8'h00) begin bad++; $display("FAIL rm_after got g=%0d p=%h to=%0d exp g=0 p=00", g, p, to); end
        run_txn(2'b10, 1'b0, g, p, to);
        total++; if (to || g !== 1 || p !== 8'h19) begin bad++; $display("FAIL rm_drain got g=%0d p=%h to=%0d exp g=1 p=19", g, p, to); end
    endtask

`ifdef MULT_SCHED_STATS_EN
    task automatic test_stats();
        int g; logic [7:0] p; bit to;
        int tos = 0;
        do_reset();
        total++; if (c0 !== 8'd0 || c1 !== 8'd0) begin bad++; $display("FAIL stats_reset got c0=%0d c1=%0d exp 0 0", c0, c1); end
        mif.req_alpha = 8'h11; mif.req_beta = 8'h11;
        for (int i = 0; i < 3; i++) begin run_txn(2'b01, 1'b0, g, p, to); if (to) tos++; end
        for (int i = 0; i < 300; i++) begin run_txn(2'b10, 1'b0, g, p, to); if (to) tos++; end
        total++; if (tos != 0) begin bad++; $display("FAIL stats_timeout got=%0d exp=0", tos); end
        total++; if (c0 !== 8'd3) begin bad++; $display("FAIL stats_c0 got=%0d exp=3", c0); end
        total++; if (c1 !== 8'd255) begin bad++; $display("FAIL stats_c1 got=%0d exp=255", c1); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_fairness();
        test_backpressure();
        test_reset_mid();
`ifdef MULT_SCHED_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
